time_counter_hms: RTL and testbench
===================================

Name: time_counter_hms

Overview:
Time-keeping core of the digital clock; sits directly upstream of bin2bcd.
- Divides the system clock to a 1 Hz tick.
- Keeps hours, minutes and seconds as plain binary.
- Supports a manual set mode for hours and minutes.
- Each 8-bit output field drives one bin2bcd instance (i_bin), which feeds the display.

Parameters:
- CLK_FREQ_HZ, 50000000, system clock cycles per second tick (bench uses 4).
- INIT_HOUR, 0, hour value loaded at reset (0..23).
- INIT_MIN, 0, minute value loaded at reset (0..59).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- i_run  input  1  1 = prescaler advances; 0 = prescaler frozen, time holds.
- i_mode  input  2  0 = run, 1 = set hours, 2 = set minutes, 3 = hold.
- i_inc  input  1  increment request, already synchronised and debounced; acts on rising edge.
- o_sec  output  8  seconds, binary 0..59.
- o_min  output  8  minutes, binary 0..59.
- o_hour  output  8  hours, binary 0..23.
- o_tick  output  1  one-cycle pulse on every seconds advance.
- o_day_wrap  output  1  one-cycle pulse when time wraps 23:59:59 -> 00:00:00.

Interface (already decided): one clock, clk; reset rst_n is asynchronous and active-low.

Behaviour:
- Reset (async assert, sync release): o_sec=0, o_min=INIT_MIN, o_hour=INIT_HOUR, o_tick=0, o_day_wrap=0, prescaler=0, inc_d=1.
  - inc_d=1 means an i_inc already high at reset release does not count.
- All outputs registered. Bits [7:6] of every field always 0. No combinational input-to-output path.
- Prescaler: counter width ceil(log2(CLK_FREQ_HZ)).
  - Increments when i_run=1 and i_mode=0.
  - At CLK_FREQ_HZ-1 it wraps to 0 and a tick occurs.
  - i_run=0 in mode 0 freezes the prescaler at its current value.
- Tick (same edge as prescaler wrap): o_tick=1 for that one cycle; o_sec advances.
  - 59 -> 0 carries into o_min.
  - o_min 59 -> 0 carries into o_hour.
  - o_hour 23 -> 0 with all carries set asserts o_day_wrap for that same cycle.
  - All fields update on one edge; there is no intermediate state.
- First tick after reset/run start comes exactly CLK_FREQ_HZ enabled cycles later.
- Increment detect: inc_d <= i_inc every cycle. inc_pulse = i_inc & ~inc_d. One increment per rising edge, regardless of high duration.
- Mode 0 (run): inc_pulse ignored.
- Mode 1 (set hours):
  - Prescaler forced to 0; o_sec forced to 0 on the first cycle in mode.
  - inc_pulse increments o_hour; 23 -> 0; no carry; o_day_wrap stays 0.
- Mode 2 (set minutes): same as mode 1, but increments o_min; 59 -> 0 with no carry into o_hour.
- Mode 3 (hold): prescaler forced to 0, no ticks, inc_pulse ignored, fields hold (o_sec not cleared).
- Returning to mode 0: counting resumes with prescaler=0, so the next tick is CLK_FREQ_HZ cycles after the first mode-0 cycle.
- o_tick and o_day_wrap are never asserted in modes 1-3.
- Mode change on the same edge as a would-be tick: the new mode wins. The prescaler is cleared and no tick occurs.
- Reset mid-operation: all state returns immediately to reset values, including a pending inc_d and a prescaler mid-count.
- Out-of-range values are unreachable. Defensively, any value above the field maximum is treated as the maximum on the next advance (wraps to 0).

Test Plan:
- Reset then run (CLK_FREQ_HZ=4, i_run=1, mode 0) -> o_tick every 4th cycle; o_sec=1 at 4 cycles after release, o_sec=10 after 40 cycles.
- Force to 00:59:59 via set mode then run one tick -> o_hour=1, o_min=0, o_sec=0 on the same edge; o_day_wrap=0.
- Set 23:59, run 60 ticks -> o_day_wrap pulses exactly once, coincident with o_tick, as 23:59:59 -> 00:00:00.
- Mode 1, five i_inc pulses (each 3 cycles high) from hour 21 -> o_hour=2, o_min unchanged, o_sec=0, no o_tick; i_inc held high 20 cycles -> exactly one increment.
- Mode 2 at minute 59, one i_inc -> o_min=0, o_hour unchanged. Then mode 0 with i_run=0 for 50 cycles -> no ticks and time frozen; i_run=1 -> first tick after 4 cycles.
- Assert rst_n=0 mid-count (prescaler=2, time 05:06:07) for half a cycle -> outputs immediately 00:00:00 (INIT values), o_tick=0; release -> first tick 4 cycles later.

Source files
------------

// File: rtl/time_counter_hms.sv
// Hours/minutes/seconds time base: divides clk to a 1 Hz tick and supports
// manual setting of hours and minutes. All fields are plain binary, registered.
module time_counter_hms #(
    parameter int unsigned CLK_FREQ_HZ = 50000000,
    parameter int unsigned INIT_HOUR   = 0,
    parameter int unsigned INIT_MIN    = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_run,
    input  logic [1:0] i_mode,
    input  logic       i_inc,
    output logic [7:0] o_sec,
    output logic [7:0] o_min,
    output logic [7:0] o_hour,
    output logic       o_tick,
    output logic       o_day_wrap
);

    localparam int unsigned PW = (CLK_FREQ_HZ > 1) ? $clog2(CLK_FREQ_HZ) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(CLK_FREQ_HZ - 1);

    typedef enum logic [1:0] {
        MODE_RUN      = 2'd0,
        MODE_SET_HOUR = 2'd1,
        MODE_SET_MIN  = 2'd2,
        MODE_HOLD     = 2'd3
    } mode_e;

    mode_e         w_mode;
    logic [PW-1:0] r_pre,  w_pre_nxt;
    logic [5:0]    r_sec,  w_sec_nxt;
    logic [5:0]    r_min,  w_min_nxt;
    logic [5:0]    r_hour, w_hour_nxt;
    logic          r_inc_d;
    logic          r_tick, w_tick_nxt;
    logic          r_day_wrap, w_day_wrap_nxt;
    logic          w_inc_pulse;
    logic          w_sec_max, w_min_max, w_hour_max;

    assign w_mode      = mode_e'(i_mode);
    assign w_inc_pulse = i_inc & ~r_inc_d;

    // ">=" so any out-of-range value behaves as the maximum and wraps to 0
    assign w_sec_max  = (r_sec  >= 6'd59);
    assign w_min_max  = (r_min  >= 6'd59);
    assign w_hour_max = (r_hour >= 6'd23);

    always_comb begin
        w_pre_nxt      = r_pre;
        w_sec_nxt      = r_sec;
        w_min_nxt      = r_min;
        w_hour_nxt     = r_hour;
        w_tick_nxt     = 1'b0;
        w_day_wrap_nxt = 1'b0;
        unique case (w_mode)
            MODE_RUN: begin
                if (i_run) begin
                    if (r_pre >= PRE_MAX) begin
                        w_pre_nxt  = '0;
                        w_tick_nxt = 1'b1;
                        w_sec_nxt  = w_sec_max ? '0 : r_sec + 6'd1;
                        if (w_sec_max) begin
                            w_min_nxt = w_min_max ? '0 : r_min + 6'd1;
                        end
                        if (w_sec_max && w_min_max) begin
                            w_hour_nxt = w_hour_max ? '0 : r_hour + 6'd1;
                        end
                        w_day_wrap_nxt = w_sec_max & w_min_max & w_hour_max;
                    end else begin
                        w_pre_nxt = r_pre + 1'b1;
                    end
                end
            end
            MODE_SET_HOUR: begin
                w_pre_nxt = '0;
                w_sec_nxt = '0;
                if (w_inc_pulse) begin
                    w_hour_nxt = w_hour_max ? '0 : r_hour + 6'd1;
                end
            end
            MODE_SET_MIN: begin
                w_pre_nxt = '0;
                w_sec_nxt = '0;
                if (w_inc_pulse) begin
                    w_min_nxt = w_min_max ? '0 : r_min + 6'd1;
                end
            end
            MODE_HOLD: begin
                w_pre_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre      <= '0;
            r_sec      <= '0;
            r_min      <= 6'(INIT_MIN);
            r_hour     <= 6'(INIT_HOUR);
            r_inc_d    <= 1'b1;
            r_tick     <= 1'b0;
            r_day_wrap <= 1'b0;
        end else begin
            r_pre      <= w_pre_nxt;
            r_sec      <= w_sec_nxt;
            r_min      <= w_min_nxt;
            r_hour     <= w_hour_nxt;
            r_inc_d    <= i_inc;
            r_tick     <= w_tick_nxt;
            r_day_wrap <= w_day_wrap_nxt;
        end
    end

    assign o_sec      = {2'b00, r_sec};
    assign o_min      = {2'b00, r_min};
    assign o_hour     = {2'b00, r_hour};
    assign o_tick     = r_tick;
    assign o_day_wrap = r_day_wrap;

endmodule

// File: tb/tb_time_counter_hms.sv
// Self-checking bench for time_counter_hms: directed step table, hand-written
// reset sequences and randomized stimulus against a seconds-of-day model.
module tb_time_counter_hms;

    localparam int unsigned FREQ = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       i_run;
    logic [1:0] i_mode;
    logic       i_inc;
    logic [7:0] o_sec, o_min, o_hour;
    logic       o_tick, o_day_wrap;

    time_counter_hms #(
        .CLK_FREQ_HZ(FREQ),
        .INIT_HOUR  (0),
        .INIT_MIN   (0)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_run     (i_run),
        .i_mode    (i_mode),
        .i_inc     (i_inc),
        .o_sec     (o_sec),
        .o_min     (o_min),
        .o_hour    (o_hour),
        .o_tick    (o_tick),
        .o_day_wrap(o_day_wrap)
    );

    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;
    int tick_cnt   = 0;
    int wrap_cnt   = 0;

    // Reference model: time kept as seconds since midnight.
    int m_t, m_pre, m_h, m_mn;
    bit m_incd, m_tick, m_wrap, m_pulse;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_t = 0; m_pre = 0; m_incd = 1'b1; m_tick = 1'b0; m_wrap = 1'b0;
        end else begin
            m_pulse = i_inc && !m_incd;
            m_incd  = i_inc;
            m_tick  = 1'b0;
            m_wrap  = 1'b0;
            case (i_mode)
                2'd0: if (i_run) begin
                    m_pre = m_pre + 1;
                    if (m_pre == FREQ) begin
                        m_pre  = 0;
                        m_tick = 1'b1;
                        m_t    = m_t + 1;
                        if (m_t == 86400) begin
                            m_t    = 0;
                            m_wrap = 1'b1;
                        end
                    end
                end
                2'd1: begin
                    m_pre = 0;
                    m_t   = m_t - (m_t % 60);
                    if (m_pulse) begin
                        m_h = (m_t / 3600 + 1) % 24;
                        m_t = m_h * 3600 + (m_t % 3600);
                    end
                end
                2'd2: begin
                    m_pre = 0;
                    m_t   = m_t - (m_t % 60);
                    if (m_pulse) begin
                        m_mn = ((m_t / 60) % 60 + 1) % 60;
                        m_t  = (m_t / 3600) * 3600 + m_mn * 60;
                    end
                end
                default: m_pre = 0;
            endcase
        end
    end

    typedef struct {
        bit       run;
        bit [1:0] mode;
        int       pulses;
        int       hi;
        int       idle;
        int       eh, em, es;
        int       eticks;
        int       ewraps;
    } step_t;

    step_t steps[24];

    task automatic check(input string name, input int h, input int m, input int s,
                         input bit tk, input bit wr);
        vectors++;
        if (o_hour !== 8'(h) || o_min !== 8'(m) || o_sec !== 8'(s) ||
            o_tick !== tk || o_day_wrap !== wr) begin
            miscompares++;
            $display("FAIL %s @%0t: got %0d:%0d:%0d tick=%b wrap=%b, expected %0d:%0d:%0d tick=%b wrap=%b",
                     name, $time, o_hour, o_min, o_sec, o_tick, o_day_wrap, h, m, s, tk, wr);
        end
    endtask

    // One clock: sample #1 after the edge, compare against the model.
    task automatic cyc();
        @(posedge clk);
        #1;
        if (o_tick === 1'b1) tick_cnt++;
        if (o_day_wrap === 1'b1) wrap_cnt++;
        check("model", m_t / 3600, (m_t / 60) % 60, m_t % 60, m_tick, m_wrap);
    endtask

    task automatic run_step(input int idx, input step_t st);
        int t0, w0;
        t0 = tick_cnt;
        w0 = wrap_cnt;
        i_run  = st.run;
        i_mode = st.mode;
        i_inc  = 1'b0;
        for (int p = 0; p < st.pulses; p++) begin
            i_inc = 1'b1;
            repeat (st.hi) cyc();
            i_inc = 1'b0;
            cyc();
        end
        repeat (st.idle) cyc();
        vectors++;
        if (o_hour !== 8'(st.eh) || o_min !== 8'(st.em) || o_sec !== 8'(st.es) ||
            (tick_cnt - t0) != st.eticks || (wrap_cnt - w0) != st.ewraps) begin
            miscompares++;
            $display("FAIL step%0d: got %0d:%0d:%0d ticks=%0d wraps=%0d, expected %0d:%0d:%0d ticks=%0d wraps=%0d",
                     idx, o_hour, o_min, o_sec, tick_cnt - t0, wrap_cnt - w0,
                     st.eh, st.em, st.es, st.eticks, st.ewraps);
        end
    endtask

    initial begin
        //          run mode pulses hi idle  h   m   s  ticks wraps
        steps[0]  = '{1'b1, 2'd0,  0, 0,  40,  0,  0, 10, 10, 0};
        steps[1]  = '{1'b1, 2'd2, 59, 1,   1,  0, 59,  0,  0, 0};
        steps[2]  = '{1'b1, 2'd0,  0, 0, 236,  0, 59, 59, 59, 0};
        steps[3]  = '{1'b1, 2'd0,  0, 0,   4,  1,  0,  0,  1, 0};
        steps[4]  = '{1'b1, 2'd1, 22, 1,   1, 23,  0,  0,  0, 0};
        steps[5]  = '{1'b1, 2'd2, 59, 1,   1, 23, 59,  0,  0, 0};
        steps[6]  = '{1'b1, 2'd0,  0, 0, 240,  0,  0,  0, 60, 1};
        steps[7]  = '{1'b1, 2'd1, 21, 1,   1, 21,  0,  0,  0, 0};
        steps[8]  = '{1'b1, 2'd1,  5, 3,   1,  2,  0,  0,  0, 0};
        steps[9]  = '{1'b1, 2'd1,  1, 20,  1,  3,  0,  0,  0, 0};
        steps[10] = '{1'b1, 2'd2, 59, 1,   1,  3, 59,  0,  0, 0};
        steps[11] = '{1'b1, 2'd2,  1, 1,   1,  3,  0,  0,  0, 0};
        steps[12] = '{1'b0, 2'd0,  0, 0,  50,  3,  0,  0,  0, 0};
        steps[13] = '{1'b1, 2'd0,  0, 0,   4,  3,  0,  1,  1, 0};
        steps[14] = '{1'b1, 2'd3,  0, 0,  20,  3,  0,  1,  0, 0};
        steps[15] = '{1'b1, 2'd3,  3, 1,   1,  3,  0,  1,  0, 0};
        steps[16] = '{1'b1, 2'd0,  3, 1,   0,  3,  0,  2,  1, 0};
        steps[17] = '{1'b1, 2'd0,  0, 0,   2,  3,  0,  3,  1, 0};
        steps[18] = '{1'b1, 2'd0,  0, 0,   3,  3,  0,  3,  0, 0};
        steps[19] = '{1'b1, 2'd3,  0, 0,   1,  3,  0,  3,  0, 0};
        steps[20] = '{1'b1, 2'd0,  0, 0,   4,  3,  0,  4,  1, 0};
        steps[21] = '{1'b1, 2'd1,  2, 1,   1,  5,  0,  0,  0, 0};
        steps[22] = '{1'b1, 2'd2,  6, 1,   1,  5,  6,  0,  0, 0};
        steps[23] = '{1'b1, 2'd0,  0, 0,  30,  5,  6,  7,  7, 0};

        rst_n  = 1'b0;
        i_run  = 1'b1;
        i_mode = 2'd0;
        i_inc  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset", 0, 0, 0, 1'b0, 1'b0);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 24; i++) run_step(i, steps[i]);

        // Reset mid-count (05:06:07, prescaler=2) for half a cycle.
        rst_n = 1'b0;
        #1 check("async_reset", 0, 0, 0, 1'b0, 1'b0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            cyc();
            check("first_tick", 0, 0, (k == 4) ? 1 : 0, (k == 4), 1'b0);
        end

        // i_inc already high at reset release must not count.
        rst_n  = 1'b0;
        i_mode = 2'd1;
        i_inc  = 1'b1;
        @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (3) cyc();
        check("inc_at_release", 0, 0, 0, 1'b0, 1'b0);
        i_inc = 1'b0;
        cyc();
        i_inc = 1'b1;
        cyc();
        check("inc_after_release", 1, 0, 0, 1'b0, 1'b0);

        i_mode = 2'd0;
        i_inc  = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0)
                i_mode = ($urandom_range(0, 9) < 5) ? 2'd0 : 2'($urandom_range(1, 3));
            i_run = ($urandom_range(0, 7) != 0);
            i_inc = ($urandom_range(0, 3) == 0);
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
